// File: rtl/wb_sdram_master_if.sv
`default_nettype none
// ============================================================================
// Interface : wb_sdram_master_if
// Brief     : Wishbone B3 bus between the SDRAM initiator and the SDRAM
//             controller slave port (classic and incrementing-burst cycles).
// Revision  : 1.0 - initial release
// ============================================================================
interface wb_sdram_master_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32
);
  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_W-1:0]     adr_o;
  logic [DATA_W-1:0]     dat_o;
  logic [DATA_W/8-1:0]   sel_o;
  logic [2:0]            cti_o;
  logic [DATA_W-1:0]     dat_i;
  logic                  ack_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, cti_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, cti_o,
    output dat_i, ack_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_sdram_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_sdram_master
// Brief    : Wishbone B3 initiator for the SDRAM controller. Turns single and
//            burst commands into classic / incrementing-burst cycles, stages
//            write data in a FIFO and aborts cycles that never get an ack.
// Revision : 1.0 - initial release
// ============================================================================
module wb_sdram_master #(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_we_i,
  input  logic [ADDR_W-1:0]             cmd_addr_i,
  input  logic [$clog2(MAX_BURST)-1:0]  cmd_len_i,
  input  logic [DATA_W/8-1:0]           cmd_sel_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic                          rd_valid_o,
  output logic [DATA_W-1:0]             rd_data_o,
  output logic                          done_o,
  output logic                          err_o,
  wb_sdram_master_if.master             wb
);

  localparam int c_len_w = $clog2(MAX_BURST);
  localparam int c_cnt_w = c_len_w + 1;
  localparam int c_wd_w  = $clog2(TIMEOUT);

  localparam logic [2:0] c_cti_classic = 3'b000;
  localparam logic [2:0] c_cti_incr    = 3'b010;
  localparam logic [2:0] c_cti_end     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_WDATA = 2'd1,
    S_BUS        = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched command and beat tracking
  logic                  r_out_en;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_adr;
  logic [c_len_w-1:0]    r_len;
  logic [c_len_w-1:0]    r_beat;
  logic [DATA_W/8-1:0]   r_sel;
  logic [c_wd_w-1:0]     r_wdog;
  logic                  r_done;
  logic                  r_err;
  logic                  r_rd_valid;
  logic [DATA_W-1:0]     r_rd_data;

  // Write-data FIFO
  logic [DATA_W-1:0]     r_mem [MAX_BURST];
  logic [c_len_w-1:0]    r_wr_ptr;
  logic [c_len_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;

  logic                  w_bus;
  logic                  w_ack;
  logic                  w_last;
  logic                  w_expire;
  logic                  w_accept;
  logic                  w_pop_ack;
  logic                  w_full;
  logic                  w_push;
  logic [c_cnt_w-1:0]    w_need;
  logic [c_cnt_w-1:0]    w_remain;
  logic [c_cnt_w-1:0]    w_drop;
  logic [c_cnt_w-1:0]    w_count_nxt;
  logic                  w_unused;

  // Byte-lane bits of the command address are dropped; adr_o is word aligned.
  assign w_unused = ^cmd_addr_i[1:0];

  assign w_bus       = (r_state == S_BUS);
  assign w_ack       = w_bus & wb.ack_i;
  assign w_last      = (r_beat == r_len);
  assign w_expire    = w_bus & ~wb.ack_i & (r_wdog == c_wd_w'(TIMEOUT - 1));
  assign cmd_ready_o = r_out_en & (r_state == S_IDLE);
  assign w_accept    = cmd_valid_i & cmd_ready_o;
  assign w_pop_ack   = w_ack & r_we;
  assign w_full      = (r_count == c_cnt_w'(MAX_BURST));
  // A word leaving on this ack frees a slot, so a full buffer may still take a push.
  assign wr_ready_o  = r_out_en & (~w_full | w_pop_ack);
  assign w_push      = wr_valid_i & wr_ready_o;
  assign w_need      = {1'b0, r_len} + c_cnt_w'(1);
  assign w_remain    = {1'b0, r_len} - {1'b0, r_beat} + c_cnt_w'(1);
  assign w_count_nxt = r_count + c_cnt_w'(w_push) - w_drop;

  // Words leaving the FIFO: one per write ack, or every unsent word on abort
  always_comb begin
    w_drop = '0;
    if (w_pop_ack) begin
      w_drop = c_cnt_w'(1);
    end else if (w_expire & r_we) begin
      w_drop = w_remain;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = cmd_we_i ? S_WAIT_WDATA : S_BUS;
        end
      end
      S_WAIT_WDATA: begin
        if (w_count_nxt >= w_need) begin
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        if ((w_ack & w_last) | w_expire) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command latch, beat/address stepping, watchdog and status pulses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out_en   <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_sel      <= '0;
      r_wdog     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_out_en   <= 1'b1;
      r_done     <= w_ack & w_last;
      r_err      <= w_expire;
      r_rd_valid <= w_ack & ~r_we;
      if (w_ack & ~r_we) begin
        r_rd_data <= wb.dat_i;
      end
      if (w_accept) begin
        r_we   <= cmd_we_i;
        r_adr  <= {cmd_addr_i[ADDR_W-1:2], 2'b00};
        r_len  <= cmd_len_i;
        r_sel  <= cmd_sel_i;
        r_beat <= '0;
      end else if (w_ack & ~w_last) begin
        r_beat <= r_beat + c_len_w'(1);
        r_adr  <= r_adr + ADDR_W'(4);
      end
      // Held at zero outside BUS so every cycle starts with a fresh count
      if (~w_bus | wb.ack_i) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + c_wd_w'(1);
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_len_w'(1);
      end
      r_rd_ptr <= r_rd_ptr + w_drop[c_len_w-1:0];
      r_count  <= w_count_nxt;
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = r_rd_data;
  assign done_o     = r_done;
  assign err_o      = r_err;

  // Bus outputs are gated by the BUS state so they read all-zero otherwise
  assign wb.cyc_o = w_bus;
  assign wb.stb_o = w_bus;
  assign wb.we_o  = w_bus & r_we;
  assign wb.adr_o = w_bus ? r_adr : '0;
  assign wb.sel_o = w_bus ? r_sel : '0;
  assign wb.dat_o = (w_bus & r_we) ? r_mem[r_rd_ptr] : '0;
  assign wb.cti_o = ~w_bus         ? c_cti_classic :
                    (r_len == '0)  ? c_cti_classic :
                    w_last         ? c_cti_end     : c_cti_incr;

endmodule
`default_nettype wire
